// File: rtl/adc_frame_align_pkg.sv
// Shared types and constants for the ADC frame alignment controller.
package adc_frame_align_pkg;

    typedef enum logic [2:0] {
        WAIT_LOCK = 3'd0,
        SETTLE    = 3'd1,
        CHECK     = 3'd2,
        SLIP      = 3'd3,
        LOCKED    = 3'd4,
        FAIL      = 3'd5
    } align_state_t;

    localparam logic [7:0] DEFAULT_FRAME_PATTERN = 8'hF0;

endpackage

// File: rtl/adc_frame_align.sv
// Bit-slip controller: slips the ISERDES until the FCLK word matches
// the frame pattern for a qualification window, then watches for loss.
module adc_frame_align
    import adc_frame_align_pkg::*;
#(
    parameter int              WORD_W        = 8,
    parameter logic [WORD_W-1:0] FRAME_PATTERN = DEFAULT_FRAME_PATTERN,
    parameter int              SETTLE_CYCLES = 4,
    parameter int              MATCH_COUNT   = 16,
    parameter int              MAX_SLIPS     = 8,
    parameter int              LOSS_COUNT    = 4
) (
    input  logic                           divclk,
    input  logic                           rst_n,
    input  logic                           pll_locked,
    input  logic [WORD_W-1:0]              fclk_word,
    input  logic                           realign,
    output logic                           bitslip,
    output logic                           aligned,
    output logic                           align_fail,
    output logic [$clog2(MAX_SLIPS+1)-1:0] slip_count
);

    localparam int SLIP_W  = $clog2(MAX_SLIPS + 1);
    localparam int SET_W   = $clog2(SETTLE_CYCLES + 1);
    localparam int MATCH_W = $clog2(MATCH_COUNT + 1);
    localparam int MISS_W  = $clog2(LOSS_COUNT + 1);

    align_state_t       state;
    logic [SET_W-1:0]   settle_cnt;
    logic [MATCH_W-1:0] match_cnt;
    logic [MISS_W-1:0]  miss_cnt;
    logic               word_ok;

    assign word_ok = (fclk_word == FRAME_PATTERN);

    always_ff @(posedge divclk) begin
        if (!rst_n) begin
            state      <= WAIT_LOCK;
            bitslip    <= 1'b0;
            aligned    <= 1'b0;
            align_fail <= 1'b0;
            slip_count <= '0;
            settle_cnt <= '0;
            match_cnt  <= '0;
            miss_cnt   <= '0;
        end else if (!pll_locked) begin
            // align_fail survives a lock drop; only realign/reset clear it
            state      <= WAIT_LOCK;
            bitslip    <= 1'b0;
            aligned    <= 1'b0;
            slip_count <= '0;
            settle_cnt <= '0;
            match_cnt  <= '0;
            miss_cnt   <= '0;
        end else if (realign) begin
            state      <= WAIT_LOCK;
            bitslip    <= 1'b0;
            aligned    <= 1'b0;
            align_fail <= 1'b0;
            slip_count <= '0;
            settle_cnt <= '0;
            match_cnt  <= '0;
            miss_cnt   <= '0;
        end else begin
            bitslip <= 1'b0;
            unique case (state)
                WAIT_LOCK: begin
                    settle_cnt <= SET_W'(SETTLE_CYCLES);
                    state      <= SETTLE;
                end
                SETTLE: begin
                    if (settle_cnt <= SET_W'(1)) begin
                        settle_cnt <= '0;
                        match_cnt  <= '0;
                        state      <= CHECK;
                    end else begin
                        settle_cnt <= settle_cnt - SET_W'(1);
                    end
                end
                CHECK: begin
                    if (word_ok) begin
                        if (match_cnt >= MATCH_W'(MATCH_COUNT - 1)) begin
                            match_cnt <= MATCH_W'(MATCH_COUNT);
                            miss_cnt  <= '0;
                            state     <= LOCKED;
                        end else begin
                            match_cnt <= match_cnt + MATCH_W'(1);
                        end
                    end else if (slip_count < SLIP_W'(MAX_SLIPS)) begin
                        // pulse and count leave together with the SLIP state
                        bitslip    <= 1'b1;
                        slip_count <= slip_count + SLIP_W'(1);
                        state      <= SLIP;
                    end else begin
                        align_fail <= 1'b1;
                        aligned    <= 1'b0;
                        state      <= FAIL;
                    end
                end
                SLIP: begin
                    settle_cnt <= SET_W'(SETTLE_CYCLES);
                    state      <= SETTLE;
                end
                LOCKED: begin
                    if (word_ok) begin
                        miss_cnt <= '0;
                        aligned  <= 1'b1;
                    end else if (miss_cnt >= MISS_W'(LOSS_COUNT - 1)) begin
                        miss_cnt   <= '0;
                        aligned    <= 1'b0;
                        slip_count <= '0;
                        settle_cnt <= SET_W'(SETTLE_CYCLES);
                        state      <= SETTLE;
                    end else begin
                        miss_cnt <= miss_cnt + MISS_W'(1);
                        aligned  <= 1'b1;
                    end
                end
                FAIL: begin
                    aligned <= 1'b0;
                end
                default: begin
                    state <= WAIT_LOCK;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_adc_frame_align.sv
// Scoreboard bench for adc_frame_align: expected values are queued with
// the stimulus and popped when the DUT response is observed.
module tb_adc_frame_align;

    localparam logic [7:0] PAT = 8'hF0;

    logic       divclk = 1'b0;
    logic       rst_n = 1'b0;
    logic       pll_locked = 1'b0;
    logic [7:0] fclk_word;
    logic       realign = 1'b0;
    logic       bitslip;
    logic       aligned;
    logic       align_fail;
    logic [3:0] slip_count;

    logic [7:0] word_val = 8'h00;
    bit         rot_mode = 1'b0;
    int         rot = 0;

    int pulses = 0;
    int adj_err = 0;
    int gap_err = 0;
    int cyc = 0;
    int last_pulse = -100;
    bit prev_bs = 1'b0;

    int errors = 0;
    int checks = 0;
    int exp_q[$];

    function automatic logic [7:0] rotl(input logic [7:0] v, input int n);
        if (n == 0) return v;
        return 8'((v << n) | (v >> (8 - n)));
    endfunction

    assign fclk_word = rot_mode ? rotl(PAT, rot) : word_val;

    adc_frame_align dut (
        .divclk     (divclk),
        .rst_n      (rst_n),
        .pll_locked (pll_locked),
        .fclk_word  (fclk_word),
        .realign    (realign),
        .bitslip    (bitslip),
        .aligned    (aligned),
        .align_fail (align_fail),
        .slip_count (slip_count)
    );

    always #5 divclk = ~divclk;

    // Pulse monitor; also models the ISERDES rotating back on each slip
    always @(negedge divclk) begin
        cyc++;
        if (bitslip) begin
            pulses++;
            if (prev_bs) adj_err++;
            if (cyc - last_pulse < 6) gap_err++;
            last_pulse = cyc;
            if (rot_mode && rot > 0) rot--;
        end
        if (bitslip && aligned) adj_err++;
        prev_bs = bitslip;
    end

    task automatic tick();
        @(negedge divclk);
        #1;
    endtask

    task automatic pulse_realign();
        realign = 1'b1;
        tick();
        realign = 1'b0;
    endtask

    task automatic test_reset();
        int e;
        rst_n = 1'b0;
        pll_locked = 1'b0;
        repeat (3) tick();
        exp_q.push_back(0);
        exp_q.push_back(0);
        exp_q.push_back(0);
        exp_q.push_back(0);
        e = exp_q.pop_front(); checks++;
        if (int'(bitslip) !== e) begin
            errors++; $display("FAIL reset_bitslip got=%0d want=%0d", bitslip, e);
        end
        e = exp_q.pop_front(); checks++;
        if (int'(aligned) !== e) begin
            errors++; $display("FAIL reset_aligned got=%0d want=%0d", aligned, e);
        end
        e = exp_q.pop_front(); checks++;
        if (int'(align_fail) !== e) begin
            errors++; $display("FAIL reset_align_fail got=%0d want=%0d", align_fail, e);
        end
        e = exp_q.pop_front(); checks++;
        if (int'(slip_count) !== e) begin
            errors++; $display("FAIL reset_slip_count got=%0d want=%0d", slip_count, e);
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_prealigned();
        int e, n, p0;
        rot_mode = 1'b0;
        word_val = PAT;
        p0 = pulses;
        pll_locked = 1'b1;
        exp_q.push_back(22);
        exp_q.push_back(0);
        exp_q.push_back(0);
        n = 0;
        while (!aligned && n < 100) begin tick(); n++; end
        e = exp_q.pop_front(); checks++;
        if (n !== e) begin
            errors++; $display("FAIL prealigned_latency got=%0d want=%0d", n, e);
        end
        e = exp_q.pop_front(); checks++;
        if (pulses - p0 !== e) begin
            errors++; $display("FAIL prealigned_pulses got=%0d want=%0d", pulses - p0, e);
        end
        e = exp_q.pop_front(); checks++;
        if (int'(slip_count) !== e) begin
            errors++; $display("FAIL prealigned_slip_count got=%0d want=%0d", slip_count, e);
        end
    endtask

    task automatic test_rotated();
        int e, n, p0;
        rot = 3;
        rot_mode = 1'b1;
        p0 = pulses;
        pulse_realign();
        exp_q.push_back(3);
        exp_q.push_back(3);
        exp_q.push_back(1);
        n = 0;
        while (!aligned && n < 300) begin tick(); n++; end
        e = exp_q.pop_front(); checks++;
        if (pulses - p0 !== e) begin
            errors++; $display("FAIL rotated_pulses got=%0d want=%0d", pulses - p0, e);
        end
        e = exp_q.pop_front(); checks++;
        if (int'(slip_count) !== e) begin
            errors++; $display("FAIL rotated_slip_count got=%0d want=%0d", slip_count, e);
        end
        e = exp_q.pop_front(); checks++;
        if (int'(aligned) !== e) begin
            errors++; $display("FAIL rotated_aligned got=%0d want=%0d", aligned, e);
        end
        word_val = PAT;
        rot_mode = 1'b0;
    endtask

    task automatic test_locked_loss();
        int e, n, p0;
        p0 = pulses;
        word_val = 8'h00;
        repeat (3) tick();
        word_val = PAT;
        tick();
        exp_q.push_back(1);
        e = exp_q.pop_front(); checks++;
        if (int'(aligned) !== e) begin
            errors++; $display("FAIL loss_3bad_aligned got=%0d want=%0d", aligned, e);
        end
        word_val = 8'h00;
        repeat (3) tick();
        exp_q.push_back(1);
        e = exp_q.pop_front(); checks++;
        if (int'(aligned) !== e) begin
            errors++; $display("FAIL loss_pre4_aligned got=%0d want=%0d", aligned, e);
        end
        tick();
        exp_q.push_back(0);
        exp_q.push_back(0);
        e = exp_q.pop_front(); checks++;
        if (int'(aligned) !== e) begin
            errors++; $display("FAIL loss_4bad_aligned got=%0d want=%0d", aligned, e);
        end
        e = exp_q.pop_front(); checks++;
        if (int'(slip_count) !== e) begin
            errors++; $display("FAIL loss_slip_count got=%0d want=%0d", slip_count, e);
        end
        word_val = PAT;
        exp_q.push_back(21);
        exp_q.push_back(0);
        n = 0;
        while (!aligned && n < 100) begin tick(); n++; end
        e = exp_q.pop_front(); checks++;
        if (n !== e) begin
            errors++; $display("FAIL loss_relock_latency got=%0d want=%0d", n, e);
        end
        e = exp_q.pop_front(); checks++;
        if (pulses - p0 !== e) begin
            errors++; $display("FAIL loss_pulses got=%0d want=%0d", pulses - p0, e);
        end
    endtask

    task automatic test_fail();
        int e, n, p0, p1;
        word_val = 8'h00;
        p0 = pulses;
        pulse_realign();
        exp_q.push_back(8);
        exp_q.push_back(1);
        exp_q.push_back(0);
        n = 0;
        while (!align_fail && n < 200) begin tick(); n++; end
        e = exp_q.pop_front(); checks++;
        if (pulses - p0 !== e) begin
            errors++; $display("FAIL fail_pulses got=%0d want=%0d", pulses - p0, e);
        end
        e = exp_q.pop_front(); checks++;
        if (int'(align_fail) !== e) begin
            errors++; $display("FAIL fail_flag got=%0d want=%0d", align_fail, e);
        end
        e = exp_q.pop_front(); checks++;
        if (int'(aligned) !== e) begin
            errors++; $display("FAIL fail_aligned got=%0d want=%0d", aligned, e);
        end
        p1 = pulses;
        exp_q.push_back(0);
        repeat (30) tick();
        e = exp_q.pop_front(); checks++;
        if (pulses - p1 !== e) begin
            errors++; $display("FAIL fail_no_more_pulses got=%0d want=%0d", pulses - p1, e);
        end
        pll_locked = 1'b0;
        tick();
        exp_q.push_back(1);
        e = exp_q.pop_front(); checks++;
        if (int'(align_fail) !== e) begin
            errors++; $display("FAIL fail_sticky_pll got=%0d want=%0d", align_fail, e);
        end
        pll_locked = 1'b1;
        pulse_realign();
        exp_q.push_back(0);
        e = exp_q.pop_front(); checks++;
        if (int'(align_fail) !== e) begin
            errors++; $display("FAIL fail_realign_clear got=%0d want=%0d", align_fail, e);
        end
        exp_q.push_back(6);
        n = 0;
        while (!bitslip && n < 50) begin tick(); n++; end
        e = exp_q.pop_front(); checks++;
        if (n !== e) begin
            errors++; $display("FAIL fail_restart_slip got=%0d want=%0d", n, e);
        end
    endtask

    task automatic test_pll_drop();
        int e, n, p0;
        word_val = 8'h00;
        pulse_realign();
        n = 0;
        while (slip_count != 4'd2 && n < 100) begin tick(); n++; end
        checks++;
        if (n >= 100) begin
            errors++; $display("FAIL pll_drop_wait got=%0d want=2", slip_count);
        end
        word_val = PAT;
        repeat (8) tick();
        pll_locked = 1'b0;
        tick();
        exp_q.push_back(0);
        exp_q.push_back(0);
        exp_q.push_back(0);
        e = exp_q.pop_front(); checks++;
        if (int'(slip_count) !== e) begin
            errors++; $display("FAIL pll_drop_slip_count got=%0d want=%0d", slip_count, e);
        end
        e = exp_q.pop_front(); checks++;
        if (int'(aligned) !== e) begin
            errors++; $display("FAIL pll_drop_aligned got=%0d want=%0d", aligned, e);
        end
        e = exp_q.pop_front(); checks++;
        if (int'(bitslip) !== e) begin
            errors++; $display("FAIL pll_drop_bitslip got=%0d want=%0d", bitslip, e);
        end
        p0 = pulses;
        pll_locked = 1'b1;
        exp_q.push_back(22);
        exp_q.push_back(0);
        n = 0;
        while (!aligned && n < 100) begin tick(); n++; end
        e = exp_q.pop_front(); checks++;
        if (n !== e) begin
            errors++; $display("FAIL pll_relock_latency got=%0d want=%0d", n, e);
        end
        e = exp_q.pop_front(); checks++;
        if (pulses - p0 !== e) begin
            errors++; $display("FAIL pll_relock_pulses got=%0d want=%0d", pulses - p0, e);
        end
    endtask

    task automatic test_reset_in_slip();
        int e, n;
        word_val = 8'h00;
        pulse_realign();
        n = 0;
        while (!bitslip && n < 100) begin tick(); n++; end
        checks++;
        if (n >= 100) begin
            errors++; $display("FAIL rst_slip_wait got=%0d want=1", bitslip);
        end
        rst_n = 1'b0;
        tick();
        exp_q.push_back(0);
        exp_q.push_back(0);
        exp_q.push_back(0);
        e = exp_q.pop_front(); checks++;
        if (int'(bitslip) !== e) begin
            errors++; $display("FAIL rst_slip_bitslip got=%0d want=%0d", bitslip, e);
        end
        e = exp_q.pop_front(); checks++;
        if (int'(slip_count) !== e) begin
            errors++; $display("FAIL rst_slip_count got=%0d want=%0d", slip_count, e);
        end
        e = exp_q.pop_front(); checks++;
        if (int'(aligned | align_fail) !== e) begin
            errors++; $display("FAIL rst_slip_flags got=%0d want=%0d", aligned | align_fail, e);
        end
        rst_n = 1'b1;
        exp_q.push_back(6);
        n = 0;
        while (!bitslip && n < 50) begin tick(); n++; end
        e = exp_q.pop_front(); checks++;
        if (n !== e) begin
            errors++; $display("FAIL rst_restart_slip got=%0d want=%0d", n, e);
        end
    endtask

    task automatic test_pulse_shape();
        int e;
        exp_q.push_back(0);
        exp_q.push_back(0);
        e = exp_q.pop_front(); checks++;
        if (adj_err !== e) begin
            errors++; $display("FAIL pulse_adjacent got=%0d want=%0d", adj_err, e);
        end
        e = exp_q.pop_front(); checks++;
        if (gap_err !== e) begin
            errors++; $display("FAIL pulse_gap got=%0d want=%0d", gap_err, e);
        end
    endtask

    initial begin
        test_reset();
        test_prealigned();
        test_rotated();
        test_locked_loss();
        test_fail();
        test_pll_drop();
        test_reset_in_slip();
        test_pulse_shape();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
